// File: rtl/truth_table_scanner_pkg.sv
// Shared constants for the truth-table scanner: FSM encodings and table width.
// The package is imported by both the RTL and the bench.
package truth_table_scanner_pkg;

  localparam int TABLE_W = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/truth_table_scanner.sv
// Exhaustive stimulus sequencer for a 4-input combinational block: drives W through
// 0..15, samples f after a settle time, and assembles the truth table and minterm count.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               f_in,
  output logic [0:3]         w_out,
  output logic               busy,
  output logic               done,
  output logic               table_valid,
  output logic [TABLE_W-1:0] table_out,
  output logic [4:0]         ones_count,
  output logic [1:0]         state_dbg
);

  // Handshake: start is a level request sampled only on IDLE edges (ignored
  // otherwise, never queued); done is a one-cycle strobe, after which
  // table_out/ones_count stay stable with table_valid high until the next start.

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  logic [1:0] state;
  logic [3:0] settle_cnt;

  assign busy      = (state == ST_SETTLE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      w_out       <= 4'd0;
      settle_cnt  <= 4'd0;
      table_out   <= '0;
      ones_count  <= 5'd0;
      table_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_SETTLE;
            w_out       <= 4'd0;
            settle_cnt  <= 4'd0;
            table_out   <= '0;
            ones_count  <= 5'd0;
            table_valid <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt != SETTLE_LAST) begin
            settle_cnt <= settle_cnt + 4'd1;
          end else begin
            // Terminal edge of this code: the only place f_in is observed.
            table_out[w_out] <= f_in;
            ones_count       <= ones_count + {4'd0, f_in};
            settle_cnt       <= 4'd0;
            if (w_out == 4'd15) begin
              state       <= ST_DONE;
              table_valid <= 1'b1;
            end else begin
              w_out <= w_out + 4'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
